// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t        : loader FSM state encoding
//   WORD_BYTES     : bytes per instruction word
//   LANE_W         : width of the byte-lane counter
//   accepts_bytes(): 1 in the states where the loader consumes stream bytes
// -----------------------------------------------------------------------------
package boot_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 2;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Terminal states stop consuming bytes; everything else takes the stream.
  function automatic logic accepts_bytes(input state_t s);
    logic r;
    case (s)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: r = 1'b1;
      S_DONE, S_ERR:                  r = 1'b0;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs little-endian bytes into 32-bit words. The first byte of a word lands
// in bits [7:0]. When the fourth byte is pushed, the completed word is
// registered on word_out and word_valid pulses high for exactly one cycle.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   push       in   byte_in is consumed this cycle
//   byte_in    in   8-bit data byte
//   clr        in   synchronous clear of lane, partial word and pulse
//   word_out   out  last completed word (holds until the next completion)
//   word_valid out  one-cycle pulse, the cycle after the fourth byte
// -----------------------------------------------------------------------------
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  byte_in,
  input  logic        clr,
  output logic [31:0] word_out,
  output logic        word_valid
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  logic [LANE_W-1:0] lane;
  logic [23:0]       partial;

  // Lane counter, right-shifting partial word, completed word and write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= '0;
      partial    <= 24'h00_0000;
      word_out   <= 32'h0000_0000;
      word_valid <= 1'b0;
    end else if (clr) begin
      lane       <= '0;
      partial    <= 24'h00_0000;
      word_out   <= word_out;
      word_valid <= 1'b0;
    end else if (push) begin
      lane       <= lane + LANE_W'(1);
      // Bytes enter at the top and move down, so after three pushes
      // partial = {b2, b1, b0} and the fourth byte tops off the word.
      partial    <= {byte_in, partial[23:8]};
      word_out   <= (lane == LAST_LANE) ? {byte_in, partial} : word_out;
      word_valid <= (lane == LAST_LANE);
    end else begin
      lane       <= lane;
      partial    <= partial;
      word_out   <= word_out;
      word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Receives a framed program image (LEN_LO, LEN_HI, 4*N data bytes, CSUM),
// writes the packed words into instruction memory and keeps the CPU in reset
// until the whole image has arrived and its XOR checksum matches.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   byte-stream valid
//   in_data    in   byte-stream data
//   in_ready   out  loader takes a byte this cycle (transfer = valid & ready)
//   imem_we    out  one-cycle instruction-memory write strobe per word
//   imem_addr  out  word address of the write
//   imem_wdata out  word written
//   cpu_rst    out  active-high CPU reset, released only in S_DONE
//   done       out  image loaded and verified (sticky until rst)
//   err        out  oversize length or checksum mismatch (sticky until rst)
// ADDR_W must stay below 16 so the 16-bit length field covers the capacity.
// -----------------------------------------------------------------------------
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 3;   // counts data bytes, up to 4 * 2^ADDR_W
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic [7:0]        len_lo;
  logic [15:0]       len_full;
  logic              too_long;
  logic [ADDR_W:0]   len_words;
  logic [CNT_W-1:0]  byte_cnt;
  logic [CNT_W-1:0]  last_idx;
  logic              last_byte;
  logic [7:0]        csum;
  logic [ADDR_W:0]   addr;
  logic              word_valid;
  logic [31:0]       word_out;

  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len_lo};
  assign too_long  = {1'b0, len_full} > MAX_WORDS;
  assign last_idx  = {len_words, 2'b00} - CNT_W'(1);
  assign last_byte = (byte_cnt == last_idx);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .push       (accept && (state == S_DATA)),
    .byte_in    (in_data),
    .clr        (accept && (state == S_LEN1)),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  // The counter cannot pass capacity for an accepted length; the MSB guard
  // keeps a corrupted counter from ever aliasing onto low addresses.
  assign imem_we    = word_valid && !addr[ADDR_W];
  assign imem_addr  = addr[ADDR_W-1:0];
  assign imem_wdata = word_out;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LEN0;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_LEN0: begin
        if (accept) next_state = S_LEN1;
        else        next_state = state;
      end
      S_LEN1: begin
        if (!accept)               next_state = state;
        else if (too_long)         next_state = S_ERR;
        else if (len_full == 16'd0) next_state = S_CSUM;
        else                       next_state = S_DATA;
      end
      S_DATA: begin
        if (accept && last_byte) next_state = S_CSUM;
        else                     next_state = state;
      end
      S_CSUM: begin
        if (!accept)              next_state = state;
        else if (in_data == csum) next_state = S_DONE;
        else                      next_state = S_ERR;
      end
      S_DONE:  next_state = S_DONE;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_ERR;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        in_ready = accepts_bytes(state);
      end
    endcase
  end

  // Length capture, data-byte counter and running checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo    <= 8'h00;
      len_words <= '0;
      byte_cnt  <= '0;
      csum      <= 8'h00;
    end else if (accept) begin
      case (state)
        S_LEN0: begin
          len_lo <= in_data;
        end
        S_LEN1: begin
          len_words <= len_full[ADDR_W:0];
          byte_cnt  <= '0;
          csum      <= 8'h00;
        end
        S_DATA: begin
          byte_cnt <= byte_cnt + CNT_W'(1);
          csum     <= csum ^ in_data;
        end
        default: begin
          len_lo <= len_lo;
        end
      endcase
    end else begin
      len_lo <= len_lo;
    end
  end

  // Word address advances after each write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (word_valid) begin
      addr <= addr + (ADDR_W + 1)'(1);
    end else begin
      addr <= addr;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    bit          rst_first;
    bit          valid;
    logic [7:0]  data;
    bit          e_ready;
    bit          e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    bit          e_cpu_rst;
    bit          e_done;
    bit          e_err;
  } vec_t;

  vec_t tbl[$];

  logic [7:0] frame_a [11];

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the rising edge, log writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    for (int k = 0; k < g; k++) tick();
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic add(input bit r, input bit v, input logic [7:0] d,
                     input bit er, input bit ew, input logic [7:0] ea,
                     input logic [31:0] ed, input bit ec, input bit edn, input bit ee);
    vec_t x;
    x.rst_first = r; x.valid = v; x.data = d;
    x.e_ready = er; x.e_we = ew; x.e_addr = ea; x.e_wdata = ed;
    x.e_cpu_rst = ec; x.e_done = edn; x.e_err = ee;
    tbl.push_back(x);
  endtask

  task automatic check_frame_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, wr_addr[0], 32'd0);
      chk({tag, "_d0"}, wr_data[0], 32'h1234_5678);
      chk({tag, "_a1"}, wr_addr[1], 32'd1);
      chk({tag, "_d1"}, wr_data[1], 32'hDEAD_BEEF);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    frame_a = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

    //   r  v  data   rdy we addr  wdata          crst done err
    // Frame A: good two-word image
    add(1, 0, 8'h00, 1, 0, 8'd0, 32'h0000_0000, 1, 0, 0);
    add(0, 1, 8'h02, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h78, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h56, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h34, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h12, 1, 1, 8'd0, 32'h1234_5678, 1, 0, 0);
    add(0, 1, 8'hEF, 1, 0, 8'd1, 32'h0,         1, 0, 0);
    add(0, 1, 8'hBE, 1, 0, 8'd1, 32'h0,         1, 0, 0);
    add(0, 1, 8'hAD, 1, 0, 8'd1, 32'h0,         1, 0, 0);
    add(0, 1, 8'hDE, 1, 1, 8'd1, 32'hDEAD_BEEF, 1, 0, 0);
    add(0, 1, 8'h2A, 0, 0, 8'd2, 32'h0,         0, 1, 0);
    add(0, 1, 8'h55, 0, 0, 8'd2, 32'h0,         0, 1, 0);
    // Frame B: same data, bad checksum
    add(1, 0, 8'h00, 1, 0, 8'd0, 32'h0000_0000, 1, 0, 0);
    add(0, 1, 8'h02, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h78, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h56, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h34, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h12, 1, 1, 8'd0, 32'h1234_5678, 1, 0, 0);
    add(0, 1, 8'hEF, 1, 0, 8'd1, 32'h0,         1, 0, 0);
    add(0, 1, 8'hBE, 1, 0, 8'd1, 32'h0,         1, 0, 0);
    add(0, 1, 8'hAD, 1, 0, 8'd1, 32'h0,         1, 0, 0);
    add(0, 1, 8'hDE, 1, 1, 8'd1, 32'hDEAD_BEEF, 1, 0, 0);
    add(0, 1, 8'h2B, 0, 0, 8'd2, 32'h0,         1, 0, 1);
    add(0, 1, 8'h2A, 0, 0, 8'd2, 32'h0,         1, 0, 1);
    // Frame C: empty image
    add(1, 0, 8'h00, 1, 0, 8'd0, 32'h0000_0000, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h00, 0, 0, 8'd0, 32'h0,         0, 1, 0);
    // Frame D: N = 257 overflows a 256-word memory
    add(1, 0, 8'h00, 1, 0, 8'd0, 32'h0000_0000, 1, 0, 0);
    add(0, 1, 8'h01, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h01, 0, 0, 8'd0, 32'h0,         1, 0, 1);
    add(0, 1, 8'h00, 0, 0, 8'd0, 32'h0,         1, 0, 1);
    // Frame E: N = 256 is accepted; first word and a stall
    add(1, 0, 8'h00, 1, 0, 8'd0, 32'h0000_0000, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h01, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h01, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 0, 8'h99, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h02, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h03, 1, 0, 8'd0, 32'h0,         1, 0, 0);
    add(0, 1, 8'h04, 1, 1, 8'd0, 32'h0403_0201, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'd1, 32'h0,         1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      if (v.rst_first) begin
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
      end else begin
        in_valid = v.valid;
        in_data  = v.data;
        tick();
        in_valid = 1'b0;
      end
      chk($sformatf("vec%0d_ready", i), in_ready, v.e_ready);
      chk($sformatf("vec%0d_we", i), imem_we, v.e_we);
      chk($sformatf("vec%0d_addr", i), imem_addr, v.e_addr);
      if (v.e_we || v.rst_first)
        chk($sformatf("vec%0d_wdata", i), imem_wdata, v.e_wdata);
      chk($sformatf("vec%0d_cpu_rst", i), cpu_rst, v.e_cpu_rst);
      chk($sformatf("vec%0d_done", i), done, v.e_done);
      chk($sformatf("vec%0d_err", i), err, v.e_err);
      if (v.rst_first) begin
        tick();
        rst = 1'b1;
      end
    end

    // Random valid gaps: same writes and final state as back-to-back.
    do_reset();
    for (int i = 0; i < 11; i++) send_byte(frame_a[i], 3);
    for (int k = 0; k < 3; k++) tick();
    check_frame_writes("gaps");

    // Reset after 6 data bytes, then a clean reload.
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(frame_a[i], 0);
    tick();
    chk("mid_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) chk("mid_a0", wr_addr[0], 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_cpu_rst", cpu_rst, 1);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_ready", in_ready, 1);
    tick();
    chk("mid_rst_we_held", imem_we, 0);
    rst = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 11; i++) send_byte(frame_a[i], 0);
    for (int k = 0; k < 3; k++) tick();
    check_frame_writes("reload");

    // A write strobe in flight is dropped by an asynchronous reset.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(frame_a[i], 0);
    chk("inflight_we_before", imem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("inflight_we_dropped", imem_we, 0);
    chk("inflight_wdata", imem_wdata, 32'h0);
    tick();
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
